// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - streaming 3x3 window generator with edge replication
module window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic        ed_in,
  output logic        in_ready,
  output logic [23:0] a,
  output logic [23:0] b,
  output logic [23:0] c,
  output logic [23:0] d,
  output logic [23:0] e,
  output logic [23:0] f,
  output logic [23:0] g,
  output logic [23:0] h,
  output logic [23:0] i,
  output logic        ed_out,
  output logic        win_valid
);

  localparam int NUM = IMG_W * IMG_H;
  localparam int NW  = $clog2(NUM + 1);
  localparam int PW  = $clog2(IMG_W);
  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [NW-1:0] r_n;
  logic [XW-1:0] r_fc;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic [24:0] r_lb0 [IMG_W];
  logic [24:0] r_lb1 [IMG_W];
  logic [24:0] r_cl [3];
  logic [24:0] r_cc [3];
  logic [24:0] w_cr [3];
  logic [23:0] w_wl [3];
  logic [23:0] w_wr [3];
  logic [23:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_i;
  logic        r_ed_out, r_win_valid, r_in_ready;
  logic        w_accept, w_adv, w_emit, w_restart;
  logic [PW-1:0] w_wptr;
  logic [24:0] w_din, w_lb0_rd, w_lb1_rd;
  logic        w_xl, w_xr, w_yt, w_yb;
  logic        w_unused_ed;

  // Next-state and per-cycle control: advance the window pipeline, emit, restart
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_emit      = 1'b0;
    w_restart   = 1'b0;
    w_accept    = pix_valid & r_in_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept && pix_sof) begin
          w_restart   = 1'b1;
          w_adv       = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL, S_STREAM: begin
        if (w_accept) begin
          w_adv = 1'b1;
          if (pix_sof) begin
            w_restart   = 1'b1;
            w_state_nxt = S_FILL;
          end else if (r_state == S_FILL) begin
            if (r_n == NW'(IMG_W)) w_state_nxt = S_STREAM;
          end else begin
            w_emit = 1'b1;
            if (r_n == NW'(NUM - 1)) w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        w_adv  = 1'b1;
        w_emit = 1'b1;
        if (r_fc == XW'(IMG_W)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line buffer addressing and the incoming right-hand column of the window
  always_comb begin
    w_wptr   = w_restart ? '0 : r_ptr;
    w_din    = (r_state == S_FLUSH) ? 25'd0 : {ed_in, pix_in};
    w_lb0_rd = r_lb0[w_wptr];
    w_lb1_rd = r_lb1[w_wptr];
    w_cr[0]  = w_lb1_rd;
    w_cr[1]  = w_lb0_rd;
    w_cr[2]  = w_din;
  end

  // Edge replication: substitute the centre column/row for out-of-image ones
  always_comb begin
    w_xl = (r_cx == '0);
    w_xr = (r_cx == PW'(IMG_W - 1));
    w_yt = (r_cy == '0);
    w_yb = (r_cy == YW'(IMG_H - 1));
    for (int k = 0; k < 3; k++) begin
      w_wl[k] = w_xl ? r_cc[k][23:0] : r_cl[k][23:0];
      w_wr[k] = w_xr ? r_cc[k][23:0] : w_cr[k][23:0];
    end
  end

  assign w_unused_ed = ^{r_cl[0][24], r_cl[1][24], r_cl[2][24]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Input index, flush, line-pointer and centre-coordinate counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n   <= '0;
      r_fc  <= '0;
      r_ptr <= '0;
      r_cx  <= '0;
      r_cy  <= '0;
    end else if (w_restart) begin
      r_n   <= NW'(1);
      r_fc  <= '0;
      r_ptr <= PW'(1);
      r_cx  <= '0;
      r_cy  <= '0;
    end else begin
      if (w_adv) r_ptr <= (r_ptr == PW'(IMG_W - 1)) ? '0 : r_ptr + PW'(1);
      if (w_adv && r_state != S_FLUSH) r_n <= r_n + NW'(1);
      r_fc <= (r_state == S_FLUSH) ? r_fc + XW'(1) : '0;
      if (w_emit) begin
        if (r_cx == PW'(IMG_W - 1)) begin
          r_cx <= '0;
          r_cy <= r_cy + YW'(1);
        end else begin
          r_cx <= r_cx + PW'(1);
        end
      end
    end
  end

  // Two cascaded line delays and the column shift window
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_lb0[w_wptr] <= w_din;
      r_lb1[w_wptr] <= w_lb0_rd;
      for (int k = 0; k < 3; k++) begin
        r_cl[k] <= r_cc[k];
        r_cc[k] <= w_cr[k];
      end
    end
  end

  // Registered window outputs; taps hold while no window is emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_i} <= '0;
      r_ed_out    <= 1'b0;
      r_win_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_win_valid <= w_emit;
      r_in_ready  <= (w_state_nxt != S_FLUSH);
      if (w_emit) begin
        r_a      <= w_yt ? w_wl[1] : w_wl[0];
        r_b      <= w_yt ? r_cc[1][23:0] : r_cc[0][23:0];
        r_c      <= w_yt ? w_wr[1] : w_wr[0];
        r_d      <= w_wl[1];
        r_e      <= r_cc[1][23:0];
        r_f      <= w_wr[1];
        r_g      <= w_yb ? w_wl[1] : w_wl[2];
        r_h      <= w_yb ? r_cc[1][23:0] : r_cc[2][23:0];
        r_i      <= w_yb ? w_wr[1] : w_wr[2];
        r_ed_out <= r_cc[1][24];
      end
    end
  end

  assign {a, b, c, d, e, f, g, h, i} = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_i};
  assign ed_out    = r_ed_out;
  assign win_valid = r_win_valid;
  assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - scoreboard bench for window_3x3_gen
module tb_window_3x3_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int NUM = W * H;

  typedef struct packed {
    int           centre;
    int           due;
    logic         ed;
    logic [215:0] taps;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  logic [23:0] pix_in;
  logic pix_valid, pix_sof, ed_in;
  logic in_ready, ed_out, win_valid;
  logic [23:0] a, b, c, d, e, f, g, h, i;

  window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .ed_in(ed_in), .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .g(g), .h(h), .i(i), .ed_out(ed_out), .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int low_run = 0;
  int last_low = 0;
  win_t sbq[$];
  logic [24:0] m_pix [NUM];
  bit m_active = 0;
  int m_n = 0;
  int m_flush_rem = 0;
  logic [215:0] log_taps [NUM];
  logic         log_ed [NUM];
  logic [215:0] ref_taps [NUM];

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [24:0] pat(input int n);
    logic [24:0] v;
    v[7:0]   = 8'(n);
    v[15:8]  = 8'(n + 16);
    v[23:16] = 8'(n + 32);
    v[24]    = n[0];
    return v;
  endfunction

  function automatic logic [215:0] mk_taps(input int cn);
    int cx = cn % W;
    int cy = cn / W;
    int k = 0;
    int xx, yy;
    logic [215:0] t = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = cx + dx; yy = cy + dy;
        if (xx < 0) xx = 0;
        if (xx > W - 1) xx = W - 1;
        if (yy < 0) yy = 0;
        if (yy > H - 1) yy = H - 1;
        t[k*24 +: 24] = m_pix[yy*W + xx][23:0];
        k++;
      end
    end
    return t;
  endfunction

  task automatic push_win(input int cn, input int due);
    win_t w;
    w.centre = cn;
    w.due    = due;
    w.ed     = m_pix[cn][24];
    w.taps   = mk_taps(cn);
    sbq.push_back(w);
  endtask

  task automatic model_accept(input bit s, input logic [24:0] dat);
    if (s) begin
      m_active = 1;
      m_n = 0;
    end else if (!m_active) begin
      return;
    end
    m_pix[m_n] = dat;
    if (m_n >= W + 1) push_win(m_n - W - 1, cyc + 1);
    if (m_n == NUM - 1) begin
      for (int k = 0; k <= W; k++) push_win(NUM - W - 1 + k, cyc + 2 + k);
      m_active = 0;
      m_flush_rem = W + 1;
    end
    m_n++;
  endtask

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every presented window
  always @(negedge clk) begin
    logic [215:0] got;
    win_t ex;
    if (win_valid === 1'b1) begin
      pulses++;
      got = {i, h, g, f, e, d, c, b, a};
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_window actual=%h cycle=%0d required=none", got, cyc);
      end else begin
        ex = sbq.pop_front();
        if (got !== ex.taps || ed_out !== ex.ed || cyc != ex.due) begin
          failures++;
          $display("FAIL window_c%0d actual=%h ed=%b cyc=%0d required=%h ed=%b cyc=%0d",
                   ex.centre, got, ed_out, cyc, ex.taps, ex.ed, ex.due);
        end
        log_taps[ex.centre] = got;
        log_ed[ex.centre]   = ed_out;
      end
    end
  end

  // One driven cycle: inputs set after the edge, handshake evaluated at negedge
  task automatic beat(input bit v, input bit s, input logic [24:0] dat, output bit acc);
    bit exp_rdy;
    pix_valid = v; pix_sof = s; pix_in = dat[23:0]; ed_in = dat[24];
    @(negedge clk);
    exp_rdy = (m_flush_rem == 0);
    check(in_ready === exp_rdy, "in_ready", longint'(in_ready), longint'(exp_rdy));
    if (!exp_rdy) m_flush_rem--;
    if (in_ready === 1'b0) low_run++;
    else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end
    acc = v && (in_ready === 1'b1);
    if (acc) model_accept(s, dat);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) beat(0, 0, 25'd0, acc);
  endtask

  task automatic put(input logic [24:0] dat, input bit s, input bit gaps);
    bit acc = 0;
    int tries = 0;
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    while (!acc && tries < 50) begin
      beat(1, s, dat, acc);
      tries++;
    end
    if (!acc) check(0, "put_timeout", tries, 50);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1; pix_valid = 0; pix_sof = 0;
    @(posedge clk); #1;
    sbq.delete();
    m_active = 0; m_flush_rem = 0; m_n = 0; low_run = 0;
    @(negedge clk);
    check({in_ready, win_valid, ed_out, a, b, c, d, e, f, g, h, i} == '0, "reset_outputs",
          longint'({in_ready, win_valid, ed_out}), 0);
    repeat (ncyc - 1) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check(in_ready === 1'b0, "ready_after_reset", longint'(in_ready), 0);
    @(posedge clk); #1;
  endtask

  task automatic pattern_frame(input int gap_after, input int gap_len);
    for (int n = 0; n < NUM; n++) begin
      put(pat(n), n == 0, 0);
      if (n == gap_after) idle(gap_len);
    end
  endtask

  function automatic bit r_match(input logic [215:0] t, input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    int ev [9];
    ev = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int k = 0; k < 9; k++) if (t[k*24 +: 8] != 8'(ev[k])) return 0;
    return 1;
  endfunction

  function automatic bit logs_equal_ref();
    for (int k = 0; k < NUM; k++) if (log_taps[k] !== ref_taps[k]) return 0;
    return 1;
  endfunction

  task automatic clear_logs();
    for (int k = 0; k < NUM; k++) begin
      log_taps[k] = '0;
      log_ed[k] = 1'b0;
    end
  endtask

  initial begin
    bit acc;
    logic [215:0] t5;
    int rs;
    rst = 1; pix_in = '0; pix_valid = 0; pix_sof = 0; ed_in = 0;
    clear_logs();
    do_reset(3);

    // Full frame, continuous valid
    pulses = 0;
    pattern_frame(-1, 0);
    idle(10);
    check(pulses == NUM, "full_pulses", pulses, NUM);
    check(last_low == W + 1, "flush_ready_low", last_low, W + 1);
    check(r_match(log_taps[0], 0, 0, 1, 0, 0, 1, 4, 4, 5) && log_ed[0] == 0, "first_window",
          longint'(log_taps[0][7:0]), 0);
    t5 = log_taps[5];
    check(r_match(t5, 0, 1, 2, 4, 5, 6, 8, 9, 10) && log_ed[5] == 1, "centre5_r",
          longint'(t5[103:96]), 5);
    check(t5[111:104] == 8'd21 && t5[119:112] == 8'd37, "centre5_gb",
          longint'(t5[119:104]), longint'({8'd37, 8'd21}));
    check(r_match(log_taps[11], 6, 7, 7, 10, 11, 11, 10, 11, 11), "last_window",
          longint'(log_taps[11][103:96]), 11);
    for (int k = 0; k < NUM; k++) ref_taps[k] = log_taps[k];

    // Stall after n=7
    clear_logs(); pulses = 0;
    pattern_frame(7, 3);
    idle(10);
    check(pulses == NUM, "stall_pulses", pulses, NUM);
    check(logs_equal_ref(), "stall_same_windows", 0, 0);

    // Restart at n=8
    pulses = 0;
    for (int n = 0; n < 8; n++) put(pat(n), n == 0, 0);
    pattern_frame(-1, 0);
    idle(10);
    check(pulses == 3 + NUM, "restart_pulses", pulses, 3 + NUM);

    // Reset during flush, then a full frame
    pattern_frame(-1, 0);
    idle(2);
    do_reset(2);
    clear_logs(); pulses = 0;
    pattern_frame(-1, 0);
    idle(10);
    check(pulses == NUM, "post_reset_pulses", pulses, NUM);
    check(logs_equal_ref(), "post_reset_windows", 0, 0);
    check(last_low == W + 1, "post_reset_flush_low", last_low, W + 1);

    // Random frames: junk without sof, random gaps, random restarts
    for (int fr = 0; fr < 6; fr++) begin
      repeat ($urandom_range(0, 3)) beat(1, 0, 25'($urandom), acc);
      rs = (fr % 2 == 1) ? $urandom_range(1, NUM - 1) : NUM;
      for (int n = 0; n < rs; n++) put(25'($urandom), n == 0, 1);
      if (rs < NUM) for (int n = 0; n < NUM; n++) put(25'($urandom), n == 0, 1);
      idle($urandom_range(0, 8));
    end
    idle(12);
    check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
